dwt53_lift_stream: RTL and testbench
====================================

# dwt53_lift_stream

Parametrised streaming 1-D LeGall 5/3 forward lifting engine for the JPEG-2000 DWT datapath. It accepts one signed sample per handshake beat and emits one (s, d) coefficient pair for every two input samples. Symmetric boundary extension is applied at both ends of each line. The block replaces single-step combinational predict/update cells in the row and column transform passes.

## Interface
- DW, 16: input sample width, signed two's complement.
- LINE_LEN, 8: samples per line; must be even and at least 4.
- CW, $clog2(LINE_LEN): width of the internal position counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_x  in  DW  signed input sample.
- out_valid  out  1  coefficient pair valid.
- out_ready  in  1  downstream accepts the pair.
- out_s  out  DW+1  signed low-pass coefficient s[n].
- out_d  out  DW+1  signed high-pass coefficient d[n].
- out_last  out  1  marks the final pair of a line.
- sat  out  1  sticky saturation flag; see Configuration.

## Operation
- Reset is asynchronous and active-low on rst_n; the clock is clk.
- Forward lifting:
  - d[n] = x[2n+1] − floor((x[2n] + x[2n+2]) / 2)
  - s[n] = x[2n] + floor((d[n−1] + d[n] + 2) / 4)
- Implement the floor operations as arithmetic right shifts. Internal sums are DW+2 / DW+3 bits wide, so no intermediate value wraps.
- Boundary handling:
  - Right edge: x[LINE_LEN] = x[LINE_LEN−2], so the last d = x[N−1] − x[N−2].
  - Left edge: d[−1] = d[0].
- Registers: x_even (the last even sample), d_prev, and a position counter pos (0..LINE_LEN−1).
- FSM states and transitions:
  - FIRST: accepts x[0] into x_even, then goes to ODD.
  - ODD: accepts x[2n+1] into x_odd.
    - If pos = LINE_LEN−1, computes the final pair, sets out_last, and goes to FIRST.
    - Otherwise goes to EVEN.
  - EVEN: accepts x[2n+2], computes pair n, loads d_prev ← d[n] and x_even ← x[2n+2], then goes to ODD.
- Output register: a single stage holding out_s, out_d and out_last.
- Backpressure:
  - in_ready = !out_valid || out_ready, in every state.
  - Stalling on FIRST and ODD beats keeps line ordering strict.
- Out-of-range LINE_LEN (odd or less than 4) is a configuration error with undefined behaviour.

## Timing
- Reset values: out_valid=0, out_s=0, out_d=0, out_last=0, sat=0, in_ready=1, state=FIRST, pos=0, d_prev=0, x_even=0.
- Latency:
  - Pair n appears registered one cycle after the beat that accepts x[2n+2].
  - The last pair appears one cycle after the beat that accepts x[LINE_LEN−1].
- Throughput: one sample per cycle when out_ready is held high, i.e. LINE_LEN/2 pairs per LINE_LEN cycles.
- Output hold: the outputs hold while out_valid && !out_ready.
- Simultaneous events: with out_valid && out_ready and a pair-producing input beat in the same cycle, the new pair loads and out_valid stays 1.
- Back-to-back lines: x[0] of the next line may be accepted on the cycle after the last odd sample. No bubble is inserted.
- Reset mid-line: the partial line is discarded, all state returns to the reset values, and the next accepted sample is treated as x[0].

## Configuration
- Macro: LIFT53_SAT_EN.
- Defined:
  - out_s and out_d are clamped to the signed DW range [−2^(DW−1), 2^(DW−1)−1] and sign-extended to DW+1 bits.
  - sat is set on any clamp and cleared only by rst_n.
  - d_prev always stores the unclamped d.
- Undefined: out_s and out_d carry full DW+1 precision, and sat is tied to 0.

## Test plan
- Ramp line (DW=16, LINE_LEN=8), out_ready=1, x = 164,164,164,156,108,200,254,156 -> required pairs:
  - (s,d) = (164,0), (169,20), (118,19), (234,−98)
  - out_last set on the 4th pair only.
- Constant line, all x=92, two consecutive lines -> 8 pairs of (92,0), out_last on pairs 4 and 8, no idle cycle between lines.
- Backpressure:
  - Stimulus: the ramp line with out_ready toggling 1,0,0,1 repeatedly.
  - Required: identical pair sequence, each pair held stable while stalled, and in_ready=0 whenever out_valid && !out_ready.
- Reset mid-line:
  - Stimulus: assert rst_n low after x[3] of the ramp, then feed a constant line of 92.
  - Required: all outputs 0 during reset, then four pairs of (92,0) with no residue from the prior line.
- Extremes (LINE_LEN=4), x = 32767, −32768, 32767, 32767:
  - Macro undefined: (0,−65535), (16383,0), sat=0.
  - LIFT53_SAT_EN defined: (0,−32768), (16383,0), sat=1 and it stays 1.

Source files
------------

// File: rtl/dwt53_lift_stream.sv
// Streaming LeGall 5/3 forward lifting: one sample in per beat, one (s, d) pair out per two samples,
// symmetric extension at both line ends. Optional output clamping and sticky sat flag via LIFT53_SAT_EN.
module dwt53_lift_stream #(
    parameter int DW       = 16,
    parameter int LINE_LEN = 8,
    parameter int CW       = $clog2(LINE_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW:0]   out_s,
    output logic [DW:0]   out_d,
    output logic          out_last,
    output logic          sat,
    output logic [1:0]    state_dbg
);

    // Handshake: a beat transfers on a rising edge where valid && ready; once valid is raised,
    // data is held stable until ready is seen. in_ready never depends on in_valid.

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        ODD   = 2'd1,
        EVEN  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   pos;
    logic [DW-1:0]   x_even;
    logic [DW-1:0]   x_odd;
    logic [DW+1:0]   d_prev;

    logic            accept;
    logic signed [DW+1:0] xe2, xo2, xi2;
    logic signed [DW+1:0] sum_e, half_e, d_even, d_last, d_new, d_left;
    logic signed [DW+2:0] d3, dl3, xe3, upd, upd_q, s3;
    logic [DW:0]          s_out, d_out;
    logic                 s_hit, d_hit;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign state_dbg = state;

    assign xe2 = {{2{x_even[DW-1]}}, x_even};
    assign xo2 = {{2{x_odd[DW-1]}}, x_odd};
    assign xi2 = {{2{in_x[DW-1]}}, in_x};

    // Predict: interior pairs use the mean of the two even neighbours; the last pair mirrors x[N-2].
    assign sum_e  = xe2 + xi2;
    assign half_e = sum_e >>> 1;
    assign d_even = xo2 - half_e;
    assign d_last = xi2 - xe2;
    assign d_new  = (state == ODD) ? d_last : d_even;

    // Update: the first pair of a line mirrors d[0] in place of d[-1].
    assign d_left = (state == EVEN && pos == CW'(2)) ? d_new : d_prev;
    assign d3     = {d_new[DW+1], d_new};
    assign dl3    = {d_left[DW+1], d_left};
    assign xe3    = {xe2[DW+1], xe2};
    assign upd    = dl3 + d3 + (DW+3)'(2);
    assign upd_q  = upd >>> 2;
    assign s3     = xe3 + upd_q;

`ifdef LIFT53_SAT_EN
    localparam logic signed [DW+2:0] SMAX = (DW+3)'((1 << (DW-1)) - 1);
    localparam logic signed [DW+2:0] SMIN = ~SMAX;

    always_comb begin
        s_out = s3[DW:0];
        d_out = d_new[DW:0];
        s_hit = 1'b0;
        d_hit = 1'b0;
        if (s3 > SMAX) begin
            s_out = SMAX[DW:0];
            s_hit = 1'b1;
        end else if (s3 < SMIN) begin
            s_out = SMIN[DW:0];
            s_hit = 1'b1;
        end
        if (d3 > SMAX) begin
            d_out = SMAX[DW:0];
            d_hit = 1'b1;
        end else if (d3 < SMIN) begin
            d_out = SMIN[DW:0];
            d_hit = 1'b1;
        end
    end
`else
    logic unused_bits;

    always_comb begin
        s_out = s3[DW:0];
        d_out = d_new[DW:0];
        s_hit = 1'b0;
        d_hit = 1'b0;
    end

    assign unused_bits = ^{s3[DW+2:DW+1], s_hit, d_hit};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FIRST;
            pos       <= '0;
            x_even    <= '0;
            x_odd     <= '0;
            d_prev    <= '0;
            out_valid <= 1'b0;
            out_s     <= '0;
            out_d     <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                case (state)
                    FIRST: begin
                        x_even <= in_x;
                        pos    <= CW'(1);
                        state  <= ODD;
                    end
                    ODD: begin
                        x_odd <= in_x;
                        if (pos == CW'(LINE_LEN - 1)) begin
                            out_valid <= 1'b1;
                            out_s     <= s_out;
                            out_d     <= d_out;
                            out_last  <= 1'b1;
                            pos       <= '0;
                            state     <= FIRST;
                        end else begin
                            pos   <= pos + CW'(1);
                            state <= EVEN;
                        end
                    end
                    EVEN: begin
                        out_valid <= 1'b1;
                        out_s     <= s_out;
                        out_d     <= d_out;
                        out_last  <= 1'b0;
                        d_prev    <= d_new;
                        x_even    <= in_x;
                        pos       <= pos + CW'(1);
                        state     <= ODD;
                    end
                    default: begin
                        state <= FIRST;
                        pos   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef LIFT53_SAT_EN
    // Sticky: only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (accept && ((state == EVEN) || (state == ODD && pos == CW'(LINE_LEN - 1)))
                     && (s_hit || d_hit)) begin
            sat <= 1'b1;
        end
    end
`else
    assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_dwt53_lift_stream.sv
// Directed bench for dwt53_lift_stream: an 8-sample instance for the line tests and a
// 4-sample instance for the extreme-value line.
`timescale 1ns/1ps
module tb_dwt53_lift_stream;

    localparam int DW = 16;
    localparam int PW = 2 * (DW + 1) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 8-sample instance
    logic          in_valid, in_ready, out_valid, out_ready, out_last, sat;
    logic [DW-1:0] in_x;
    logic [DW:0]   out_s, out_d;
    logic [1:0]    state_dbg;

    // 4-sample instance
    logic          in_valid4, in_ready4, out_valid4, out_last4, sat4;
    logic          out_ready4;
    logic [DW-1:0] in_x4;
    logic [DW:0]   out_s4, out_d4;
    logic [1:0]    state_dbg4;

    dwt53_lift_stream #(.DW(DW), .LINE_LEN(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_d(out_d), .out_last(out_last),
        .sat(sat), .state_dbg(state_dbg)
    );

    dwt53_lift_stream #(.DW(DW), .LINE_LEN(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_x(in_x4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_s(out_s4), .out_d(out_d4), .out_last(out_last4),
        .sat(sat4), .state_dbg(state_dbg4)
    );

    // ---------------- scoreboard ----------------
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp4_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit bp_mode  = 1'b0;
    int cyc      = 0;

    function automatic logic [PW-1:0] pk(input int s, input int d, input bit last);
        logic [DW:0] sv, dv;
        sv = s[DW:0];
        dv = d[DW:0];
        return {sv, dv, last};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // out_ready pattern 1,0,0,1 in backpressure mode, otherwise always ready
    always @(negedge clk) begin
        cyc++;
        if (bp_mode) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        else         out_ready = 1'b1;
    end

    // monitor for the 8-sample instance
    logic [PW-1:0] hold_val;
    bit            hold_pend = 1'b0;
    always @(negedge clk) begin
        logic [PW-1:0] e;
        #2;
        if (rst_n) begin
            if (hold_pend) begin
                check("hold", {out_valid, out_s, out_d, out_last}, {1'b1, hold_val});
                hold_pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pair", {out_s, out_d, out_last}, 64'hdead);
                end else begin
                    e = exp_q.pop_front();
                    check("pair", {out_s, out_d, out_last}, e);
                end
            end else if (out_valid) begin
                check("stall_in_ready", in_ready, 0);
                hold_val  = {out_s, out_d, out_last};
                hold_pend = 1'b1;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    // monitor for the 4-sample instance
    always @(negedge clk) begin
        logic [PW-1:0] e;
        #2;
        if (rst_n && out_valid4 && out_ready4) begin
            if (exp4_q.size() == 0) begin
                check("unexpected_pair4", {out_s4, out_d4, out_last4}, 64'hdead);
            end else begin
                e = exp4_q.pop_front();
                check("pair4", {out_s4, out_d4, out_last4}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int x, output int stalls);
        int guard;
        guard  = 0;
        stalls = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x[DW-1:0];
        #1;
        while (!in_ready && guard < 50) begin
            stalls++;
            guard++;
            @(negedge clk);
            #1;
        end
        if (guard >= 50) check("send_timeout", guard, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_line(input int xs[8], input int n, output int stalls);
        int st;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            send(xs[i], st);
            stalls += st;
        end
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || exp4_q.size() != 0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        check(name, exp_q.size() + exp4_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        #2;
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_s"},     out_s, 0);
        check({tag, "_out_d"},     out_d, 0);
        check({tag, "_out_last"},  out_last, 0);
        check({tag, "_sat"},       sat, 0);
        check({tag, "_in_ready"},  in_ready, 1);
        check({tag, "_state"},     state_dbg, 0);
    endtask

    // ---------------- stimulus ----------------
    int ramp[8]  = '{164, 164, 164, 156, 108, 200, 254, 156};
    int konst[8] = '{92, 92, 92, 92, 92, 92, 92, 92};
    int ext4[4]  = '{32767, -32768, 32767, 32767};

    initial begin
        int st, st2;
        rst_n = 1'b0;
        in_valid = 1'b0; in_x = '0;
        in_valid4 = 1'b0; in_x4 = '0; out_ready4 = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ramp line, always ready
        exp_q.push_back(pk(164, 0, 0));
        exp_q.push_back(pk(169, 20, 0));
        exp_q.push_back(pk(118, 19, 0));
        exp_q.push_back(pk(234, -98, 1));
        send_line(ramp, 8, st);
        check("ramp_stalls", st, 0);

        // two back-to-back constant lines
        for (int i = 0; i < 8; i++) exp_q.push_back(pk(92, 0, (i % 4) == 3));
        send_line(konst, 8, st);
        send_line(konst, 8, st2);
        check("b2b_stalls", st + st2, 0);
        drain("drain_const");
        check("ramp_sat", sat, 0);

        // ramp line under backpressure
        bp_mode = 1'b1;
        exp_q.push_back(pk(164, 0, 0));
        exp_q.push_back(pk(169, 20, 0));
        exp_q.push_back(pk(118, 19, 0));
        exp_q.push_back(pk(234, -98, 1));
        send_line(ramp, 8, st);
        drain("drain_bp");
        bp_mode = 1'b0;
        repeat (2) @(negedge clk);

        // reset after x[3] of a ramp line
        exp_q.push_back(pk(164, 0, 0));
        send_line(ramp, 4, st);
        drain("drain_partial");
        check("partial_state", state_dbg, 2);
        @(negedge clk);
        rst_n = 1'b0;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(pk(92, 0, i == 3));
        send_line(konst, 8, st);
        drain("drain_after_reset");

        // extreme values on the 4-sample instance
`ifdef LIFT53_SAT_EN
        exp4_q.push_back(pk(0, -32768, 0));
`else
        exp4_q.push_back(pk(0, -65535, 0));
`endif
        exp4_q.push_back(pk(16383, 0, 1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid4 = 1'b1;
            in_x4     = ext4[i][DW-1:0];
            #1;
            check("ext_in_ready", in_ready4, 1);
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        drain("drain_ext");
`ifdef LIFT53_SAT_EN
        check("ext_sat", sat4, 1);
        repeat (5) @(negedge clk);
        check("ext_sat_sticky", sat4, 1);
`else
        check("ext_sat", sat4, 0);
        repeat (5) @(negedge clk);
        check("ext_sat_idle", sat4, 0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
